// File: rtl/lcd_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_scan_ctrl
//  Description : Display-path sequencer. Selects one of six datapath sources
//                for the board display mux, captures the selected value into
//                a stable register, and scans that value onto an 8-digit
//                multiplexed hex display.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_scan_ctrl #(
    parameter int DWELL  = 50_000_000,  // cycles on one source after capture (>=2)
    parameter int SETTLE = 2,           // cycles SLCT is held before capture (>=1)
    parameter int SCAN   = 50_000       // cycles each digit stays enabled (>=1)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        AUTO,
    input  logic [4:0]  MAN_SLCT,
    input  logic        HOLD,
    input  logic        STEP,
    input  logic [31:0] RESULT,
    output logic [4:0]  SLCT,
    output logic [2:0]  SLOT,
    output logic [31:0] SHOW,
    output logic        SHOW_VLD,
    output logic [7:0]  DIG_EN,
    output logic [3:0]  NIBBLE
);

    // One counter serves both the settle phase and the dwell phase, so it
    // must be wide enough for the larger of the two terminal counts.
    localparam int c_CNT_MAX  = (DWELL > SETTLE) ? DWELL : SETTLE;
    localparam int c_CNT_W    = $clog2(c_CNT_MAX + 1);
    localparam int c_SCAN_W   = (SCAN > 1) ? $clog2(SCAN) : 1;

    localparam logic [c_CNT_W-1:0]  c_SET_LAST  = c_CNT_W'(SETTLE - 1);
    localparam logic [c_CNT_W-1:0]  c_DWL_LAST  = c_CNT_W'(DWELL - 1);
    localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN - 1);

    typedef enum logic [1:0] {
        ST_SEL = 2'd0,
        ST_CAP = 2'd1,
        ST_DWL = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [2:0]           r_slot;
    logic [2:0]           w_slot_nxt;
    logic [2:0]           w_slot_inc;
    logic [4:0]           r_slct;
    logic [4:0]           w_slct_nxt;
    logic                 r_auto_q;
    logic                 w_auto_tog;
    logic                 w_enter_sel;
    logic                 w_cap;
    logic [31:0]          r_show;
    logic                 r_show_vld;
    logic [c_SCAN_W-1:0]  r_scan_cnt;
    logic [7:0]           r_dig_en;
    logic [3:0]           w_nibble;

    // Slot index to display-mux select code.
    function automatic logic [4:0] slot_code(input logic [2:0] s);
        case (s)
            3'd0:    slot_code = 5'b00000;
            3'd1:    slot_code = 5'b00010;
            3'd2:    slot_code = 5'b00100;
            3'd3:    slot_code = 5'b01000;
            3'd4:    slot_code = 5'b10000;
            3'd5:    slot_code = 5'b01110;
            default: slot_code = 5'b00000;
        endcase
    endfunction

    assign w_auto_tog = (AUTO != r_auto_q);
    assign w_slot_inc = (r_slot == 3'd5) ? 3'd0 : r_slot + 3'd1;

    // Next-state logic: restart events in priority order, then normal sequencing.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_slot_nxt  = r_slot;
        w_slct_nxt  = r_slct;
        w_enter_sel = 1'b0;
        w_cap       = 1'b0;

        if (w_auto_tog) begin
            w_enter_sel = 1'b1;
        end else if (!AUTO && (MAN_SLCT != r_slct)) begin
            w_enter_sel = 1'b1;
        end else if (AUTO && STEP && (r_state == ST_DWL)) begin
            w_slot_nxt  = w_slot_inc;
            w_enter_sel = 1'b1;
        end else begin
            case (r_state)
                ST_SEL: begin
                    if (r_cnt == c_SET_LAST) begin
                        w_state_nxt = ST_CAP;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_CAP: begin
                    w_cap       = 1'b1;
                    w_state_nxt = ST_DWL;
                    w_cnt_nxt   = '0;
                end
                ST_DWL: begin
                    if (r_cnt == c_DWL_LAST) begin
                        if (AUTO && !HOLD) begin
                            w_slot_nxt = w_slot_inc;
                        end
                        // Always revisit SEL so a held or manual source is re-captured.
                        w_enter_sel = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_SEL;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        if (w_enter_sel) begin
            w_state_nxt = ST_SEL;
            w_cnt_nxt   = '0;
            w_slct_nxt  = AUTO ? slot_code(w_slot_nxt) : MAN_SLCT;
        end
    end

    // Sequencer state, select register and capture register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_SEL;
            r_cnt      <= '0;
            r_slot     <= 3'd0;
            r_slct     <= 5'b00000;
            r_show     <= 32'h0;
            r_show_vld <= 1'b0;
            // Track the live mode so leaving reset is not seen as a toggle.
            r_auto_q   <= AUTO;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_slot     <= w_slot_nxt;
            r_slct     <= w_slct_nxt;
            r_auto_q   <= AUTO;
            r_show_vld <= w_cap;
            if (w_cap) begin
                r_show <= RESULT;
            end
        end
    end

    // Free-running digit scan, independent of the sequencer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_scan_cnt <= '0;
            r_dig_en   <= 8'h01;
        end else if (r_scan_cnt == c_SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_dig_en   <= {r_dig_en[6:0], r_dig_en[7]};
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // Nibble for the enabled digit, straight from the capture register.
    always_comb begin
        w_nibble = 4'h0;
        for (int i = 0; i < 8; i++) begin
            if (r_dig_en[i]) begin
                w_nibble = w_nibble | r_show[4*i +: 4];
            end
        end
    end

    assign SLCT     = r_slct;
    assign SLOT     = r_slot;
    assign SHOW     = r_show;
    assign SHOW_VLD = r_show_vld;
    assign DIG_EN   = r_dig_en;
    assign NIBBLE   = w_nibble;

endmodule
`default_nettype wire

// File: tb/tb_lcd_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_scan_ctrl
//  Description : Self-checking bench for lcd_scan_ctrl (DWELL=8, SETTLE=1,
//                SCAN=4). Expected captures are queued as stimulus is set up
//                and compared when SHOW_VLD pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_scan_ctrl;

    logic        CLK;
    logic        RST;
    logic        AUTO;
    logic [4:0]  MAN_SLCT;
    logic        HOLD;
    logic        STEP;
    logic [31:0] RESULT;
    logic [4:0]  SLCT;
    logic [2:0]  SLOT;
    logic [31:0] SHOW;
    logic        SHOW_VLD;
    logic [7:0]  DIG_EN;
    logic [3:0]  NIBBLE;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } cap_t;

    cap_t exp_q[$];
    cap_t e;
    int   cyc;
    int   checks;
    int   failures;

    lcd_scan_ctrl #(
        .DWELL  (8),
        .SETTLE (1),
        .SCAN   (4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .AUTO     (AUTO),
        .MAN_SLCT (MAN_SLCT),
        .HOLD     (HOLD),
        .STEP     (STEP),
        .RESULT   (RESULT),
        .SLCT     (SLCT),
        .SLOT     (SLOT),
        .SHOW     (SHOW),
        .SHOW_VLD (SHOW_VLD),
        .DIG_EN   (DIG_EN),
        .NIBBLE   (NIBBLE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [4:0] tbl(input int s);
        logic [4:0] t [6];
        t = '{5'b00000, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01110};
        return t[s % 6];
    endfunction

    function automatic cap_t mk(input int c, input logic [31:0] v);
        cap_t r;
        r.cyc = c;
        r.val = v;
        return r;
    endfunction

    // Advance one cycle; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        AUTO = 1'b1; HOLD = 1'b0; STEP = 1'b0; MAN_SLCT = 5'b00000;
        RESULT = 32'h1234_ABCD;
        do_reset();
        checks += 6;
        if (SLCT !== 5'b00000) begin failures++; $display("FAIL reset_slct got=%b exp=00000", SLCT); end
        if (SLOT !== 3'd0) begin failures++; $display("FAIL reset_slot got=%0d exp=0", SLOT); end
        if (SHOW !== 32'h0) begin failures++; $display("FAIL reset_show got=%h exp=0", SHOW); end
        if (SHOW_VLD !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", SHOW_VLD); end
        if (DIG_EN !== 8'h01) begin failures++; $display("FAIL reset_digen got=%h exp=01", DIG_EN); end
        if (NIBBLE !== 4'h0) begin failures++; $display("FAIL reset_nibble got=%h exp=0", NIBBLE); end
        RST = 1'b0;
        cyc = 0;
    endtask

    task automatic test_auto_rotate();
        for (int k = 0; k < 6; k++) exp_q.push_back(mk(2 + 10 * k, 32'h1234_ABCD));
        for (int c = 0; c <= 60; c++) begin
            if (c > 0) tick();
            checks += 3;
            if (SLOT !== 3'((cyc / 10) % 6)) begin
                failures++; $display("FAIL rot_slot cyc=%0d got=%0d exp=%0d", cyc, SLOT, (cyc / 10) % 6);
            end
            if (SLCT !== tbl(cyc / 10)) begin
                failures++; $display("FAIL rot_slct cyc=%0d got=%b exp=%b", cyc, SLCT, tbl(cyc / 10));
            end
            if (SHOW !== ((cyc >= 2) ? 32'h1234_ABCD : 32'h0)) begin
                failures++; $display("FAIL rot_show cyc=%0d got=%h", cyc, SHOW);
            end
            if (SHOW_VLD !== 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rot_cap unexpected cyc=%0d show=%h", cyc, SHOW);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || SHOW !== e.val) begin
                        failures++; $display("FAIL rot_cap got cyc=%0d val=%h exp cyc=%0d val=%h", cyc, SHOW, e.cyc, e.val);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL rot_missed got=%0d pending exp=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_hold_step();
        int es;
        exp_q.push_back(mk(62, 32'h1234_ABCD));
        exp_q.push_back(mk(72, 32'h1234_ABCD));
        exp_q.push_back(mk(82, 32'h1234_ABCD));
        exp_q.push_back(mk(92, 32'hCAFE_0002));
        exp_q.push_back(mk(102, 32'hCAFE_0002));
        exp_q.push_back(mk(108, 32'h0000_0008));
        while (cyc < 110) begin
            tick();
            es = (cyc < 80) ? (cyc - 60) / 10 : ((cyc < 106) ? 2 : 3);
            checks += 2;
            if (SLOT !== 3'(es)) begin
                failures++; $display("FAIL hold_slot cyc=%0d got=%0d exp=%0d", cyc, SLOT, es);
            end
            if (SLCT !== tbl(es)) begin
                failures++; $display("FAIL hold_slct cyc=%0d got=%b exp=%b", cyc, SLCT, tbl(es));
            end
            if (SHOW_VLD !== 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL hold_cap unexpected cyc=%0d show=%h", cyc, SHOW);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || SHOW !== e.val) begin
                        failures++; $display("FAIL hold_cap got cyc=%0d val=%h exp cyc=%0d val=%h", cyc, SHOW, e.cyc, e.val);
                    end
                end
            end
            if (cyc == 80) HOLD = 1'b1;
            if (cyc == 85) RESULT = 32'hCAFE_0002;
            if (cyc == 105) STEP = 1'b1;
            if (cyc == 106) begin STEP = 1'b0; HOLD = 1'b0; RESULT = 32'h0000_0008; end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL hold_missed got=%0d pending exp=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_manual();
        logic [4:0] ec;
        exp_q.push_back(mk(114, 32'h0000_0010));
        exp_q.push_back(mk(125, 32'h0000_0004));
        exp_q.push_back(mk(135, 32'h0000_0004));
        exp_q.push_back(mk(139, 32'h0000_0008));
        while (cyc < 140) begin
            tick();
            if (cyc <= 111)      ec = 5'b01000;
            else if (cyc <= 122) ec = 5'b10000;
            else if (cyc <= 136) ec = 5'b00100;
            else                 ec = 5'b01000;
            checks += 2;
            if (SLOT !== 3'd3) begin
                failures++; $display("FAIL man_slot cyc=%0d got=%0d exp=3", cyc, SLOT);
            end
            if (SLCT !== ec) begin
                failures++; $display("FAIL man_slct cyc=%0d got=%b exp=%b", cyc, SLCT, ec);
            end
            if (SHOW_VLD !== 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL man_cap unexpected cyc=%0d show=%h", cyc, SHOW);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || SHOW !== e.val) begin
                        failures++; $display("FAIL man_cap got cyc=%0d val=%h exp cyc=%0d val=%h", cyc, SHOW, e.cyc, e.val);
                    end
                end
            end
            if (cyc == 111) begin AUTO = 1'b0; MAN_SLCT = 5'b10000; RESULT = 32'h0000_0010; end
            if (cyc == 122) begin MAN_SLCT = 5'b00100; RESULT = 32'h0000_0004; end
            if (cyc == 127) STEP = 1'b1;
            if (cyc == 128) STEP = 1'b0;
            if (cyc == 136) begin AUTO = 1'b1; RESULT = 32'h0000_0008; end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL man_missed got=%0d pending exp=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_scan();
        logic [7:0] ed;
        logic [3:0] en;
        AUTO = 1'b1; HOLD = 1'b0; STEP = 1'b0;
        RESULT = 32'h8765_4321;
        do_reset();
        RST = 1'b0;
        cyc = 0;
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(2 + 10 * k, 32'h8765_4321));
        for (int c = 0; c <= 36; c++) begin
            if (c > 0) tick();
            ed = 8'h01 << ((cyc / 4) % 8);
            en = (cyc >= 2) ? 4'(((cyc / 4) % 8) + 1) : 4'h0;
            checks += 2;
            if (DIG_EN !== ed) begin
                failures++; $display("FAIL scan_digen cyc=%0d got=%h exp=%h", cyc, DIG_EN, ed);
            end
            if (NIBBLE !== en) begin
                failures++; $display("FAIL scan_nibble cyc=%0d got=%h exp=%h", cyc, NIBBLE, en);
            end
            if (SHOW_VLD !== 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL scan_cap unexpected cyc=%0d show=%h", cyc, SHOW);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || SHOW !== e.val) begin
                        failures++; $display("FAIL scan_cap got cyc=%0d val=%h exp cyc=%0d val=%h", cyc, SHOW, e.cyc, e.val);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL scan_missed got=%0d pending exp=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_in_cap();
        // Continue from cycle 36 of the scan run: slot 4 is in CAP at cycle 41.
        while (cyc < 41) begin
            tick();
            checks++;
            if (SHOW_VLD !== 1'b0) begin
                failures++; $display("FAIL rcap_pre_vld cyc=%0d got=%b exp=0", cyc, SHOW_VLD);
            end
        end
        checks++;
        if (SLCT !== 5'b10000) begin failures++; $display("FAIL rcap_slct_pre got=%b exp=10000", SLCT); end
        RESULT = 32'hDEAD_BEEF;
        RST = 1'b1;
        tick();
        checks += 6;
        if (SHOW !== 32'h0) begin failures++; $display("FAIL rcap_show got=%h exp=0", SHOW); end
        if (SHOW_VLD !== 1'b0) begin failures++; $display("FAIL rcap_vld got=%b exp=0", SHOW_VLD); end
        if (SLCT !== 5'b00000) begin failures++; $display("FAIL rcap_slct got=%b exp=00000", SLCT); end
        if (SLOT !== 3'd0) begin failures++; $display("FAIL rcap_slot got=%0d exp=0", SLOT); end
        if (DIG_EN !== 8'h01) begin failures++; $display("FAIL rcap_digen got=%h exp=01", DIG_EN); end
        if (NIBBLE !== 4'h0) begin failures++; $display("FAIL rcap_nibble got=%h exp=0", NIBBLE); end
        tick();
        checks++;
        if (SHOW_VLD !== 1'b0) begin failures++; $display("FAIL rcap_vld2 got=%b exp=0", SHOW_VLD); end
        RST = 1'b0;
        cyc = 0;
        exp_q.push_back(mk(2, 32'hDEAD_BEEF));
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) tick();
            if (SHOW_VLD !== 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rcap_cap unexpected cyc=%0d show=%h", cyc, SHOW);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || SHOW !== e.val) begin
                        failures++; $display("FAIL rcap_cap got cyc=%0d val=%h exp cyc=%0d val=%h", cyc, SHOW, e.cyc, e.val);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL rcap_missed got=%0d pending exp=0", exp_q.size()); end
        exp_q.delete();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        RST      = 1'b1;
        AUTO     = 1'b1;
        MAN_SLCT = 5'b00000;
        HOLD     = 1'b0;
        STEP     = 1'b0;
        RESULT   = 32'h0;
        test_reset();
        test_auto_rotate();
        test_hold_step();
        test_manual();
        test_scan();
        test_reset_in_cap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
